// File: rtl/layered_color_mapper.sv
// Layered pixel compositor: rotated tanks, square bullets, maze and
// per-tank hit flash resolved by a fixed-priority stack, 3-cycle pipeline.
//
// Ports:
//   CLK, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank pixel coordinate and visible flag (blank=1 visible)
//   frame_tick          one pulse per frame, steps the flash counters
//   maze                wall flag aligned with DrawX/DrawY
//   tank_*              packed per-tank centre, heading, colour, hit pulse
//   tank_size           shared half-width of every tank body
//   bul_*               packed per-bullet centre, half-size, enable
//   Red, Green, Blue    registered colour, 3 CLK after the pixel
//   tank_flashing       registered, 1 while a tank's flash counter runs
module layered_color_mapper #(
    parameter int NUM_TANKS    = 2,
    parameter int NUM_BULLETS  = 6,
    parameter int COORD_W      = 10,
    parameter int HEAD_HALF    = 6,
    parameter int FLASH_FRAMES = 24,
    localparam int NB = (NUM_BULLETS > 0) ? NUM_BULLETS : 1
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       blank,
    input  logic                       frame_tick,
    input  logic                       maze,
    input  logic [NUM_TANKS*COORD_W-1:0] tank_x,
    input  logic [NUM_TANKS*COORD_W-1:0] tank_y,
    input  logic [COORD_W-1:0]         tank_size,
    input  logic [NUM_TANKS*8-1:0]     tank_sin,
    input  logic [NUM_TANKS*8-1:0]     tank_cos,
    input  logic [NUM_TANKS*24-1:0]    tank_color,
    input  logic [NUM_TANKS-1:0]       tank_hit,
    input  logic [NB*COORD_W-1:0]      bul_x,
    input  logic [NB*COORD_W-1:0]      bul_y,
    input  logic [NB*COORD_W-1:0]      bul_s,
    input  logic [NB-1:0]              bul_active,
    output logic [7:0]                 Red,
    output logic [7:0]                 Green,
    output logic [7:0]                 Blue,
    output logic [NUM_TANKS-1:0]       tank_flashing
);

    localparam int DW = COORD_W + 1;
    // Room for an 8-bit product plus the dot-product carry.
    localparam int PW = DW + 9;
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic signed [PW-1:0] HH = PW'(HEAD_HALF);

    // ---------------- flash counters
    logic [FW-1:0]        flash_cnt [NUM_TANKS];
    logic [FW-1:0]        flash_nxt [NUM_TANKS];
    logic [NUM_TANKS-1:0] flash_live;

    always_comb begin
        for (int t = 0; t < NUM_TANKS; t++) begin
            flash_nxt[t] = flash_cnt[t];
            // A hit in the same cycle as a tick restarts the full flash.
            if (tank_hit[t])
                flash_nxt[t] = FW'(FLASH_FRAMES);
            else if (frame_tick && flash_cnt[t] != '0)
                flash_nxt[t] = flash_cnt[t] - 1'b1;
            flash_live[t] = (flash_nxt[t] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int t = 0; t < NUM_TANKS; t++)
                flash_cnt[t] <= '0;
            tank_flashing <= '0;
        end else begin
            for (int t = 0; t < NUM_TANKS; t++)
                flash_cnt[t] <= flash_nxt[t];
            tank_flashing <= flash_live;
        end
    end

    // ---------------- S1: offsets and bullet hit
    logic signed [DW-1:0] dx_c [NUM_TANKS];
    logic signed [DW-1:0] dy_c [NUM_TANKS];
    logic signed [DW-1:0] bdx, bdy, bs;
    logic [NUM_TANKS-1:0] phase_c;
    logic                 bul_c;

    always_comb begin
        bul_c = 1'b0;
        bdx   = '0;
        bdy   = '0;
        bs    = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            dx_c[t] = $signed({1'b0, DrawX})
                    - $signed({1'b0, tank_x[t*COORD_W +: COORD_W]});
            dy_c[t] = $signed({1'b0, DrawY})
                    - $signed({1'b0, tank_y[t*COORD_W +: COORD_W]});
            phase_c[t] = (flash_cnt[t] != '0) && flash_cnt[t][2];
        end
        // All bullets paint the same colour, so index order collapses to OR.
        for (int b = 0; b < NUM_BULLETS; b++) begin
            bdx = $signed({1'b0, DrawX})
                - $signed({1'b0, bul_x[b*COORD_W +: COORD_W]});
            bdy = $signed({1'b0, DrawY})
                - $signed({1'b0, bul_y[b*COORD_W +: COORD_W]});
            bs  = $signed({1'b0, bul_s[b*COORD_W +: COORD_W]});
            if (bul_active[b] && bdx <= bs && bdx >= -bs
                && bdy <= bs && bdy >= -bs)
                bul_c = 1'b1;
        end
    end

    logic                    s1_blank, s1_maze, s1_bul;
    logic signed [DW-1:0]    s1_dx [NUM_TANKS];
    logic signed [DW-1:0]    s1_dy [NUM_TANKS];
    logic [NUM_TANKS*8-1:0]  s1_sin, s1_cos;
    logic [NUM_TANKS*24-1:0] s1_color;
    logic [COORD_W-1:0]      s1_size;
    logic [NUM_TANKS-1:0]    s1_phase;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_blank <= 1'b0;
            s1_maze  <= 1'b0;
            s1_bul   <= 1'b0;
            for (int t = 0; t < NUM_TANKS; t++) begin
                s1_dx[t] <= '0;
                s1_dy[t] <= '0;
            end
            s1_sin   <= '0;
            s1_cos   <= '0;
            s1_color <= '0;
            s1_size  <= '0;
            s1_phase <= '0;
        end else begin
            s1_blank <= blank;
            s1_maze  <= maze;
            s1_bul   <= bul_c;
            for (int t = 0; t < NUM_TANKS; t++) begin
                s1_dx[t] <= dx_c[t];
                s1_dy[t] <= dy_c[t];
            end
            s1_sin   <= tank_sin;
            s1_cos   <= tank_cos;
            s1_color <= tank_color;
            s1_size  <= tank_size;
            s1_phase <= phase_c;
        end
    end

    // ---------------- S2: rotate into tank-local (u,v)
    logic signed [PW-1:0] u_c [NUM_TANKS];
    logic signed [PW-1:0] v_c [NUM_TANKS];
    logic signed [PW-1:0] dxw, dyw, cw, sw;

    always_comb begin
        dxw = '0;
        dyw = '0;
        cw  = '0;
        sw  = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            dxw = s1_dx[t];
            dyw = s1_dy[t];
            cw  = $signed(s1_cos[t*8 +: 8]);
            sw  = $signed(s1_sin[t*8 +: 8]);
            u_c[t] = (dxw * cw + dyw * sw) >>> 7;
            v_c[t] = (dyw * cw - dxw * sw) >>> 7;
        end
    end

    logic                    s2_blank, s2_maze, s2_bul;
    logic signed [PW-1:0]    s2_u [NUM_TANKS];
    logic signed [PW-1:0]    s2_v [NUM_TANKS];
    logic [NUM_TANKS*24-1:0] s2_color;
    logic [COORD_W-1:0]      s2_size;
    logic [NUM_TANKS-1:0]    s2_phase;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s2_blank <= 1'b0;
            s2_maze  <= 1'b0;
            s2_bul   <= 1'b0;
            for (int t = 0; t < NUM_TANKS; t++) begin
                s2_u[t] <= '0;
                s2_v[t] <= '0;
            end
            s2_color <= '0;
            s2_size  <= '0;
            s2_phase <= '0;
        end else begin
            s2_blank <= s1_blank;
            s2_maze  <= s1_maze;
            s2_bul   <= s1_bul;
            for (int t = 0; t < NUM_TANKS; t++) begin
                s2_u[t] <= u_c[t];
                s2_v[t] <= v_c[t];
            end
            s2_color <= s1_color;
            s2_size  <= s1_size;
            s2_phase <= s1_phase;
        end
    end

    // ---------------- S3: shape tests and layer priority
    logic signed [PW-1:0] sz;
    logic                 head_any, body_any;
    logic [23:0]          body_rgb, rgb_c;

    always_comb begin
        sz       = $signed({{(PW-COORD_W){1'b0}}, s2_size});
        head_any = 1'b0;
        body_any = 1'b0;
        body_rgb = '0;
        // Walk high to low so the lowest-index tank is written last and wins.
        for (int t = NUM_TANKS - 1; t >= 0; t--) begin
            if (s2_u[t] >= 0 && s2_u[t] <= sz
                && s2_v[t] >= -HH && s2_v[t] <= HH)
                head_any = 1'b1;
            if (s2_u[t] >= -sz && s2_u[t] <= sz
                && s2_v[t] >= -sz && s2_v[t] <= sz) begin
                body_any = 1'b1;
                body_rgb = s2_phase[t] ? 24'hFFFFFF
                                       : s2_color[t*24 +: 24];
            end
        end
        rgb_c = 24'h555555;
        priority case (1'b1)
            !s2_blank, s2_maze, s2_bul: rgb_c = 24'h000000;
            head_any:                   rgb_c = 24'h00FFFF;
            body_any:                   rgb_c = body_rgb;
            default:                    rgb_c = 24'h555555;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            {Red, Green, Blue} <= 24'h000000;
        else
            {Red, Green, Blue} <= rgb_c;
    end

endmodule

// File: tb/tb_layered_color_mapper.sv
// Bench for layered_color_mapper: directed pixels scored through a
// 3-cycle tagged queue, plus direct reset and flash-counter checks.
module tb_layered_color_mapper;

    localparam int NT = 2;
    localparam int NB = 6;
    localparam int CW = 10;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [CW-1:0]     DrawX, DrawY;
    logic              blank, frame_tick, maze;
    logic [NT*CW-1:0]  tank_x, tank_y;
    logic [CW-1:0]     tank_size;
    logic [NT*8-1:0]   tank_sin, tank_cos;
    logic [NT*24-1:0]  tank_color;
    logic [NT-1:0]     tank_hit;
    logic [NB*CW-1:0]  bul_x, bul_y, bul_s;
    logic [NB-1:0]     bul_active;
    logic [7:0]        Red, Green, Blue;
    logic [NT-1:0]     tank_flashing;

    typedef struct {
        logic [23:0] rgb;
        int          x;
        int          y;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vecs = 0;
    int          errs = 0;
    int          fc;
    logic [4:0]  fc5;
    logic [23:0] want;
    logic        chk = 1'b0;
    logic [2:0]  chk_pipe = 3'b000;

    layered_color_mapper dut (
        .CLK(CLK), .Reset(Reset),
        .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_tick(frame_tick), .maze(maze),
        .tank_x(tank_x), .tank_y(tank_y), .tank_size(tank_size),
        .tank_sin(tank_sin), .tank_cos(tank_cos),
        .tank_color(tank_color), .tank_hit(tank_hit),
        .bul_x(bul_x), .bul_y(bul_y), .bul_s(bul_s),
        .bul_active(bul_active),
        .Red(Red), .Green(Green), .Blue(Blue),
        .tank_flashing(tank_flashing)
    );

    always #5 CLK = ~CLK;

    // Tag follows each scored pixel; it lands as the colour is due.
    always @(posedge CLK) chk_pipe <= {chk_pipe[1:0], chk};

    always @(negedge CLK) begin
        if (chk_pipe[2]) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL pixel: output with no expectation, got %h",
                         {Red, Green, Blue});
            end else begin
                mon_e = exp_q.pop_front();
                if ({Red, Green, Blue} !== mon_e.rgb) begin
                    errs++;
                    $display("FAIL pixel (%0d,%0d): got %h want %h",
                             mon_e.x, mon_e.y, {Red, Green, Blue}, mon_e.rgb);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic bl,
                       input logic mz, input logic [23:0] e);
        exp_t it;
        @(posedge CLK); #1;
        DrawX = CW'(x);
        DrawY = CW'(y);
        blank = bl;
        maze  = mz;
        chk   = 1'b1;
        it.rgb = e;
        it.x   = x;
        it.y   = y;
        exp_q.push_back(it);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            chk   = 1'b0;
            blank = 1'b0;
            maze  = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(posedge CLK);
            w++;
        end
        @(negedge CLK);
        if (exp_q.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain: %0d pixels never appeared, want 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1 frame_tick = 1'b1;
        @(posedge CLK); #1 frame_tick = 1'b0;
    endtask

    task automatic hit1();
        @(posedge CLK); #1 tank_hit = 2'b10;
        @(posedge CLK); #1 tank_hit = 2'b00;
    endtask

    task automatic set_tank(input int i, input int x, input int y,
                            input logic [7:0] s, input logic [7:0] c,
                            input logic [23:0] col);
        tank_x[i*CW +: CW]     = CW'(x);
        tank_y[i*CW +: CW]     = CW'(y);
        tank_sin[i*8 +: 8]     = s;
        tank_cos[i*8 +: 8]     = c;
        tank_color[i*24 +: 24] = col;
    endtask

    task automatic set_bul(input int i, input int x, input int y,
                           input int s, input logic act);
        bul_x[i*CW +: CW] = CW'(x);
        bul_y[i*CW +: CW] = CW'(y);
        bul_s[i*CW +: CW] = CW'(s);
        bul_active[i]     = act;
    endtask

    initial begin
        Reset      = 1'b1;
        DrawX      = 10'd10;
        DrawY      = 10'd10;
        blank      = 1'b1;
        maze       = 1'b0;
        frame_tick = 1'b0;
        tank_hit   = '0;
        tank_size  = 10'd8;
        tank_x     = '0;
        tank_y     = '0;
        tank_sin   = '0;
        tank_cos   = '0;
        tank_color = '0;
        bul_x      = '0;
        bul_y      = '0;
        bul_s      = '0;
        bul_active = '0;
        set_tank(0, 100, 100, 8'sd0, 8'sd127, 24'hFF0000);
        set_tank(1, 500, 400, 8'sd0, 8'sd127, 24'h00FF00);

        // Reset, then a visible background pixel refills the pipe.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rgb", 32'({Red, Green, Blue}), 32'h000000);
        check("rst_flash", 32'(tank_flashing), 32'h0);
        Reset = 1'b0;
        @(posedge CLK); #1;
        check("refill_a", 32'({Red, Green, Blue}), 32'h000000);
        @(posedge CLK); #1;
        check("refill_b", 32'({Red, Green, Blue}), 32'h000000);
        @(posedge CLK); #1;
        check("refill_c", 32'({Red, Green, Blue}), 32'h555555);
        blank = 1'b0;
        idle(2);

        // Heading +x: head in front, body behind, outside past size.
        pix(106, 100, 1'b1, 1'b0, 24'h00FFFF);
        pix(93, 100, 1'b1, 1'b0, 24'hFF0000);
        pix(110, 100, 1'b1, 1'b0, 24'h555555);
        pix(106, 100, 1'b0, 1'b0, 24'h000000);
        idle(1);

        // Heading +y.
        set_tank(0, 200, 200, 8'sd127, 8'sd0, 24'hFF0000);
        pix(200, 205, 1'b1, 1'b0, 24'h00FFFF);
        pix(208, 200, 1'b1, 1'b0, 24'hFF0000);
        pix(200, 195, 1'b1, 1'b0, 24'hFF0000);
        pix(205, 200, 1'b1, 1'b0, 24'h00FFFF);
        idle(1);

        // Bullet and maze over a tank body.
        set_tank(0, 100, 100, 8'sd0, 8'sd127, 24'hFF0000);
        set_bul(0, 100, 100, 2, 1'b1);
        pix(99, 100, 1'b1, 1'b0, 24'h000000);
        pix(95, 100, 1'b1, 1'b1, 24'h000000);
        pix(106, 100, 1'b1, 1'b0, 24'h00FFFF);
        idle(1);
        bul_active[0] = 1'b0;
        pix(99, 100, 1'b1, 1'b0, 24'hFF0000);
        idle(1);

        // Bullet near the left edge must not wrap.
        set_bul(5, 1, 50, 2, 1'b1);
        pix(0, 50, 1'b1, 1'b0, 24'h000000);
        pix(3, 50, 1'b1, 1'b0, 24'h000000);
        pix(4, 50, 1'b1, 1'b0, 24'h555555);
        pix(1, 53, 1'b1, 1'b0, 24'h555555);
        idle(1);
        bul_active = '0;
        drain();

        // Flash length and phase on tank 1.
        hit1();
        check("flash_load", 32'(tank_flashing), 32'h2);
        pix(495, 400, 1'b1, 1'b0, 24'h00FF00);
        idle(1);
        for (int i = 1; i <= 24; i++) begin
            tick();
            check("flash_len", 32'(tank_flashing), (i < 24) ? 32'h2 : 32'h0);
            if (i == 1 || i == 5 || i == 12 || i == 24) begin
                fc   = 24 - i;
                fc5  = 5'(fc);
                want = (fc != 0 && fc5[2]) ? 24'hFFFFFF : 24'h00FF00;
                pix(495, 400, 1'b1, 1'b0, want);
                idle(1);
            end
        end
        drain();

        // Hit coinciding with a tick reloads to the full count.
        hit1();
        repeat (3) tick();
        @(posedge CLK); #1;
        tank_hit   = 2'b10;
        frame_tick = 1'b1;
        @(posedge CLK); #1;
        tank_hit   = 2'b00;
        frame_tick = 1'b0;
        pix(495, 400, 1'b1, 1'b0, 24'h00FF00);
        idle(1);
        repeat (23) tick();
        check("reload_23", 32'(tank_flashing), 32'h2);
        tick();
        check("reload_24", 32'(tank_flashing), 32'h0);
        drain();

        // Reset mid-flash and mid-line.
        hit1();
        tick();
        check("pre_rst_flash", 32'(tank_flashing), 32'h2);
        @(posedge CLK); #1;
        DrawX = 10'd495;
        DrawY = 10'd400;
        blank = 1'b1;
        maze  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("pre_rst_rgb", 32'({Red, Green, Blue}), 32'hFFFFFF);
        Reset = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_rgb", 32'({Red, Green, Blue}), 32'h000000);
        check("mid_rst_flash", 32'(tank_flashing), 32'h0);
        Reset = 1'b0;
        @(posedge CLK); #1;
        check("resume_a", 32'({Red, Green, Blue}), 32'h000000);
        @(posedge CLK); #1;
        check("resume_b", 32'({Red, Green, Blue}), 32'h000000);
        @(posedge CLK); #1;
        check("resume_c", 32'({Red, Green, Blue}), 32'h00FF00);
        tick();
        check("post_rst_flash", 32'(tank_flashing), 32'h0);
        blank = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
